// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and parity-mode encodings
// common to the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;

    // Value the XOR of data and parity bit must equal for a good frame.
    localparam logic PAR_MODE_EVEN = 1'b0;
    localparam logic PAR_MODE_ODD  = 1'b1;

    // Parity-check failure for a frame: data XOR received parity bit must
    // equal the selected parity mode.
    function automatic logic parity_mismatch(input logic data_xor,
                                             input logic par_bit,
                                             input logic par_mode);
        return (data_xor ^ par_bit) != par_mode;
    endfunction

endpackage

// File: rtl/rx_bit_sampler.sv
// Front end of the UART receiver: two-flop synchronizer for the serial line,
// falling-edge detector and the free-running bit-clock counter whose
// mid-bit tick tells the FSM when to sample.
module rx_bit_sampler #(
    parameter int OVERSAMPLE = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic serial_in,
    input  logic cnt_clear,
    output logic line,
    output logic fall,
    output logic tick
);

    localparam int CNT_W = $clog2(OVERSAMPLE);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q,  prev_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Next-state for synchronizer, edge history and bit-clock counter.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path (here
        // unconditionally, elsewhere as a default first) so no latch is inferred.
        sync1_d = serial_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        if (cnt_clear || cnt_q == CNT_W'(OVERSAMPLE - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; the line history resets to idle-high so reset release
    // never looks like a start edge.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge
        // values, so the two synchronizer stages really form a 2-deep chain.
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    assign line = sync2_q;
    assign fall = prev_q & ~sync2_q;
    assign tick = (cnt_q == CNT_W'(OVERSAMPLE / 2 - 1));

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM (start, data LSB first, optional parity, stop
// bits, break wait) plus a one-word holding register with valid/ready
// handshake and overrun reporting.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_W     = 20,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              serialIn,
    output logic [DATA_W-1:0] rxData,
    output logic              rxValid,
    input  logic              rxReady,
    output logic              frameErr,
    output logic              parityErr,
    output logic              overrunErr,
    output logic              busy
);

    localparam int   BIT_W    = $clog2(DATA_W);
    localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_MODE_ODD : PAR_MODE_EVEN;

    logic line, fall, tick, cnt_clear;

    rx_bit_sampler #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_sampler (
        .clock    (clock),
        .reset    (reset),
        .serial_in(serialIn),
        .cnt_clear(cnt_clear),
        .line     (line),
        .fall     (fall),
        .tick     (tick)
    );

    rx_state_e         state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              frame_flag_q, frame_flag_d;
    logic              par_flag_q, par_flag_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              parity_err_q, parity_err_d;
    logic              overrun_q, overrun_d;
    logic              last_stop;
    logic              frame_err_now;

    // Frame FSM: walks the bit sequence on mid-bit ticks and flags the final stop sample.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        frame_flag_d  = frame_flag_q;
        par_flag_d    = par_flag_q;
        cnt_clear     = 1'b0;
        last_stop     = 1'b0;
        frame_err_now = frame_flag_q;
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d      = ST_START;
                    cnt_clear    = 1'b1;
                    bit_cnt_d    = '0;
                    frame_flag_d = 1'b0;
                    par_flag_d   = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    // A line back high at mid start bit was only a glitch.
                    state_d   = line ? ST_IDLE : ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = {line, shift_q[DATA_W-1:1]};
                    if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    par_flag_d = parity_mismatch(^shift_q, line, PAR_MODE);
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    frame_err_now = frame_flag_q | ~line;
                    frame_flag_d  = frame_err_now;
                    if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                        last_stop = 1'b1;
                        // A low line here is a break; wait for idle before re-arming.
                        state_d   = line ? ST_IDLE : ST_WAIT_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (line) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Holding register: load on the final stop sample when free or being drained, else report overrun.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = 1'b0;
        if (rx_valid_q && rxReady) begin
            rx_valid_d = 1'b0;
        end
        if (last_stop) begin
            if (!rx_valid_q || rxReady) begin
                rx_data_d    = shift_q;
                frame_err_d  = frame_err_now;
                parity_err_d = par_flag_q;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State and output registers; reset drops any partial frame and any held word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            frame_flag_q <= 1'b0;
            par_flag_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            frame_flag_q <= frame_flag_d;
            par_flag_q   <= par_flag_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rxData     = rx_data_q;
    assign rxValid    = rx_valid_q;
    assign frameErr   = frame_err_q;
    assign parityErr  = parity_err_q;
    assign overrunErr = overrun_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8-bit no-parity receiver and a 20-bit
// even-parity receiver, both 8 clocks per bit, driven from one sequence.
module tb_uart_rx;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;
    logic line8, line20;
    logic rdy8, rdy20;

    logic [7:0]  data8;
    logic        valid8, ferr8, perr8, ovr8, busy8;
    logic [19:0] data20;
    logic        valid20, ferr20, perr20, ovr20, busy20;

    int checks = 0;
    int errors = 0;
    int ovr8_cnt = 0;
    int ovr_base;

    uart_rx #(
        .DATA_W(8), .OVERSAMPLE(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut8 (
        .clock(clock), .reset(reset), .serialIn(line8),
        .rxData(data8), .rxValid(valid8), .rxReady(rdy8),
        .frameErr(ferr8), .parityErr(perr8), .overrunErr(ovr8), .busy(busy8)
    );

    uart_rx #(
        .DATA_W(20), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut20 (
        .clock(clock), .reset(reset), .serialIn(line20),
        .rxData(data20), .rxValid(valid20), .rxReady(rdy20),
        .frameErr(ferr20), .parityErr(perr20), .overrunErr(ovr20), .busy(busy20)
    );

    // Count overrun pulses on the 8-bit receiver.
    always @(posedge clock) begin
        if (ovr8) ovr8_cnt <= ovr8_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_line(input bit sel20, input logic v);
        if (sel20) line20 = v;
        else       line8  = v;
    endtask

    // Start bit, data bits LSB first, optional parity bit; leaves the stop bit to the caller.
    task automatic send_body(input bit sel20, input logic [31:0] data, input int nbits,
                             input bit with_par, input logic par);
        set_line(sel20, 1'b0);
        hold(8);
        for (int i = 0; i < nbits; i++) begin
            set_line(sel20, data[i]);
            hold(8);
        end
        if (with_par) begin
            set_line(sel20, par);
            hold(8);
        end
    endtask

    task automatic send_frame(input bit sel20, input logic [31:0] data, input int nbits,
                              input bit with_par, input logic par, input logic stop);
        send_body(sel20, data, nbits, with_par, par);
        set_line(sel20, stop);
        hold(8);
    endtask

    task automatic accept8();
        rdy8 = 1'b1;
        hold(1);
        rdy8 = 1'b0;
    endtask

    task automatic accept20();
        rdy20 = 1'b1;
        hold(1);
        rdy20 = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        line8  = 1'b1;
        line20 = 1'b1;
        rdy8   = 1'b0;
        rdy20  = 1'b0;
        hold(2);

        // Reset state
        check("rst_valid8", valid8, 0);
        check("rst_data8", data8, 0);
        check("rst_ferr8", ferr8, 0);
        check("rst_perr8", perr8, 0);
        check("rst_ovr8", ovr8, 0);
        check("rst_busy8", busy8, 0);
        check("rst_valid20", valid20, 0);
        check("rst_busy20", busy20, 0);
        reset = 1'b0;
        hold(4);
        check("idle_busy8", busy8, 0);

        // 0xA5, exact latency: stop sample falls after the 78th edge, valid after the 79th
        send_body(1'b0, 32'hA5, 8, 1'b0, 1'b0);
        set_line(1'b0, 1'b1);
        hold(6);
        check("a5_valid_before", valid8, 0);
        hold(1);
        check("a5_valid_at", valid8, 1);
        check("a5_data", data8, 32'hA5);
        check("a5_ferr", ferr8, 0);
        check("a5_perr", perr8, 0);
        hold(1);
        check("a5_busy_after", busy8, 0);
        accept8();
        check("a5_accept", valid8, 0);
        check("a5_data_kept", data8, 32'hA5);
        hold(8);

        // 3-clock glitch: START entered, rejected at mid-bit, busy drops 4 clocks later
        set_line(1'b0, 1'b0);
        hold(3);
        set_line(1'b0, 1'b1);
        hold(1);
        check("glitch_busy", busy8, 1);
        hold(3);
        check("glitch_busy_clear", busy8, 0);
        hold(80);
        check("glitch_no_valid", valid8, 0);

        // Back-to-back 0x11 then 0x22 with no consumer: second frame dropped
        ovr_base = ovr8_cnt;
        send_frame(1'b0, 32'h11, 8, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 32'h22, 8, 1'b0, 1'b0, 1'b1);
        hold(8);
        check("ovr_valid", valid8, 1);
        check("ovr_data_kept", data8, 32'h11);
        check("ovr_pulses", ovr8_cnt - ovr_base, 1);
        check("ovr_ferr", ferr8, 0);
        accept8();
        check("ovr_accept", valid8, 0);
        hold(8);

        // Stop bit 0 then 3 bit times low: delivered with frameErr, held in WAIT_IDLE
        send_frame(1'b0, 32'h5A, 8, 1'b0, 1'b0, 1'b0);
        hold(24);
        check("brk_valid", valid8, 1);
        check("brk_data", data8, 32'h5A);
        check("brk_ferr", ferr8, 1);
        check("brk_perr", perr8, 0);
        check("brk_busy", busy8, 1);
        accept8();
        check("brk_accept", valid8, 0);
        hold(40);
        check("brk_no_second", valid8, 0);
        check("brk_still_busy", busy8, 1);
        set_line(1'b0, 1'b1);
        hold(4);
        check("brk_busy_clear", busy8, 0);
        check("brk_no_valid", valid8, 0);
        hold(16);

        // Reset in DATA after 4 bits, with a word already held
        send_frame(1'b0, 32'h77, 8, 1'b0, 1'b0, 1'b1);
        check("pre_rst_held", valid8, 1);
        hold(8);
        set_line(1'b0, 1'b0);
        hold(8);
        for (int i = 0; i < 4; i++) begin
            set_line(1'b0, (i >= 2) ? 1'b1 : 1'b0);
            hold(8);
        end
        #1 reset = 1'b1;
        #1;
        check("mid_rst_valid", valid8, 0);
        check("mid_rst_data", data8, 0);
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_ferr", ferr8, 0);
        set_line(1'b0, 1'b1);
        hold(3);
        reset = 1'b0;
        hold(16);
        check("post_rst_valid", valid8, 0);
        check("post_rst_busy", busy8, 0);
        send_frame(1'b0, 32'h3C, 8, 1'b0, 1'b0, 1'b1);
        check("3c_valid", valid8, 1);
        check("3c_data", data8, 32'h3C);
        check("3c_ferr", ferr8, 0);
        accept8();
        hold(8);

        // Even parity on 20-bit words
        send_frame(1'b1, 32'h55555, 20, 1'b1, 1'b1, 1'b1);
        hold(4);
        check("par_bad_valid", valid20, 1);
        check("par_bad_data", data20, 32'h55555);
        check("par_bad_perr", perr20, 1);
        check("par_bad_ferr", ferr20, 0);
        accept20();
        check("par_bad_accept", valid20, 0);
        hold(8);

        send_frame(1'b1, 32'h55555, 20, 1'b1, 1'b0, 1'b1);
        hold(4);
        check("par_ok_valid", valid20, 1);
        check("par_ok_perr", perr20, 0);
        accept20();
        hold(8);

        send_frame(1'b1, 32'h00001, 20, 1'b1, 1'b1, 1'b1);
        hold(4);
        check("par_lsb_data", data20, 32'h00001);
        check("par_lsb_perr", perr20, 0);
        accept20();
        hold(8);

        send_frame(1'b1, 32'h80000, 20, 1'b1, 1'b0, 1'b1);
        hold(4);
        check("par_msb_data", data20, 32'h80000);
        check("par_msb_perr", perr20, 1);
        check("par_msb_ovr", ovr20, 0);
        accept20();
        hold(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 20, data bits per frame (5..32).
REQ-002 SHALL have parameter OVERSAMPLE, default 8, clocks per bit time (even, 4..32).
REQ-003 SHALL have parameter PARITY_EN, default 0, 1 = parity bit follows the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even parity (used only if PARITY_EN).
REQ-005 SHALL have parameter STOP_BITS, default 1, number of stop bits checked (1 or 2).
REQ-006 SHALL have port clock, input, 1, sole clock; one bit time = OVERSAMPLE clocks.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port serialIn, input, 1, asynchronous serial line; idle high.
REQ-009 SHALL have port rxData, output, DATA_W, received word, LSB first on the line.
REQ-010 SHALL have port rxValid, output, 1, rxData and flags are valid; held until accepted.
REQ-011 SHALL have port rxReady, input, 1, consumer accepts the word when rxValid && rxReady.
REQ-012 SHALL have port frameErr, output, 1, stop-bit error for the held word.
REQ-013 SHALL have port parityErr, output, 1, parity mismatch for the held word.
REQ-014 SHALL have port overrunErr, output, 1, one-cycle pulse when a completed frame is dropped.
REQ-015 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL pass serialIn through a 2-flop synchronizer; all decisions use the synchronized line.
REQ-017 SHALL use FSM states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-018 IDLE -> START on a synchronized 1->0 transition; bit-clock counter cleared to 0 on that cycle.
REQ-019 SHALL sample each bit when the counter equals OVERSAMPLE/2-1, then every OVERSAMPLE clocks; counter wraps OVERSAMPLE-1 -> 0.
REQ-020 START: line sampled 1 at mid-bit -> IDLE (glitch rejected, no output); sampled 0 -> DATA.
REQ-021 DATA: shift in exactly DATA_W samples LSB first, then -> PARITY if PARITY_EN, else -> STOP.
REQ-022 PARITY: parityErr_next = (XOR of data bits XOR sampled bit) != PARITY_ODD; SHALL be 0 when PARITY_EN=0.
REQ-023 STOP: sample STOP_BITS bits; any sample 0 sets frameErr_next; after the last stop sample -> IDLE if the line is 1, else -> WAIT_IDLE.
REQ-024 WAIT_IDLE -> IDLE only after the synchronized line is 1 (break condition not re-triggered as a start bit).
REQ-025 On the last stop sample, SHALL load rxData/frameErr/parityErr and set rxValid on the next edge if the holding register is empty or is being accepted that same cycle (rxValid && rxReady).
REQ-026 If rxValid is high and rxReady is low at that cycle, SHALL keep the held word and flags unchanged, drop the new frame, and pulse overrunErr for one cycle.
REQ-027 rxValid SHALL clear the cycle after rxValid && rxReady, unless a new word loads per REQ-025.
REQ-028 Latency: rxValid rises exactly 1 clock after the final stop-bit sample edge.
REQ-029 Frames with frameErr or parityErr SHALL still be delivered, with their flags set.

Reset
REQ-030 On reset: FSM = IDLE, counter = 0, shift register = 0, synchronizer flops = 1, rxData = 0, rxValid = 0, frameErr = parityErr = overrunErr = busy = 0.
REQ-031 Reset mid-frame SHALL discard the partial frame and any held word; after release, no output until a new start edge.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state enum and the parity-mode constants shared with the transmitter.
REQ-033 Sub-module rx_bit_sampler (synchronizer, edge detect, bit-clock counter, mid-bit tick) SHALL be a separate module; the FSM and holding register reside in uart_rx.

Verification
REQ-034 DATA_W=8, OVERSAMPLE=8, no parity: send 0xA5, 1 stop -> rxData=0xA5, rxValid 1 clock after stop sample, flags 0.
REQ-035 Default params, PARITY_EN=1 even: send 0x5_5555 with parity bit 1 -> parityErr=1; correct parity 0 -> parityErr=0.
REQ-036 3-clock low glitch with OVERSAMPLE=8 -> no rxValid, busy returns 0 within 4 clocks.
REQ-037 rxReady held 0, two back-to-back frames 0x11 then 0x22 -> rxData stays 0x11, one overrunErr pulse; accept -> rxValid=0.
REQ-038 Stop bit forced 0 then line held low 3 bit times -> frameErr=1, FSM stays in WAIT_IDLE, no second frame until line high.
REQ-039 Reset asserted in DATA after 4 bits -> all outputs 0 immediately; next clean frame 0x3C received correctly.
